// File: rtl/toggle_wd_pkg.sv
// toggle_wd_pkg: shared types and limits for the toggle watchdog
package toggle_wd_pkg;
   typedef enum logic [1:0] {DISABLED = 2'd0, ARMING = 2'd1, MONITOR = 2'd2, STUCK = 2'd3} toggle_wd_state_e;
   localparam int TW_SYNC_MAX = 3;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: input synchronizer plus previous-sample register with edge outputs
module sync_edge_det
   import toggle_wd_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic s,
   output logic rise,
   output logic fall
);
   localparam int N = SYNC_STAGES > TW_SYNC_MAX ? TW_SYNC_MAX : SYNC_STAGES;
   logic [N:0] chain;
   logic prev;
   assign chain[0] = sig_in;
   for (genvar i = 0; i < N; i++) begin : g_sync
      always_ff @(posedge clk or posedge rst)
         if (rst) chain[i+1] <= 1'b0;
         else chain[i+1] <= chain[i];
   end
   assign s = chain[N];
   always_ff @(posedge clk or posedge rst)
      if (rst) prev <= 1'b0;
      else prev <= s;
   assign rise = s & ~prev;
   assign fall = ~s & prev;
endmodule

// File: rtl/toggle_watchdog.sv
// toggle_watchdog: edge pulses, saturating toggle count and stuck detection for one signal
module toggle_watchdog
   import toggle_wd_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_W = 16,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 clr,
   input  logic                 sig_in,
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
   output logic                 rise_pulse,
   output logic                 fall_pulse,
   output logic                 toggle_pulse,
   output logic [CNT_W-1:0]     toggle_cnt,
   output logic                 stuck_now,
   output logic                 stuck_sticky,
   output logic                 stuck_level,
   output logic [1:0]           state
);
   toggle_wd_state_e st, nxt;
   logic s, rise, fall, act, ev, hit;
   logic [TIMEOUT_W-1:0] idle, idle_nxt;
   sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .sig_in(sig_in), .s(s), .rise(rise), .fall(fall)
   );
   assign act = st == MONITOR || st == STUCK;
   assign ev = act & (rise | fall);
   // idle >= timeout-1 means this edge-free sample is the timeout-th one
   assign hit = act && !ev && timeout_cycles != '0 && idle >= timeout_cycles - TIMEOUT_W'(1);
   always_comb begin
      idle_nxt = (!act || ev) ? '0 : (&idle ? idle : idle + TIMEOUT_W'(1));
      nxt = !en ? DISABLED : st == DISABLED ? ARMING : st == ARMING ? MONITOR : hit ? STUCK : ev ? MONITOR : st;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= DISABLED;
         idle <= '0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         toggle_pulse <= 1'b0;
         toggle_cnt <= '0;
         stuck_now <= 1'b0;
         stuck_sticky <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         st <= nxt;
         idle <= idle_nxt;
         rise_pulse <= act & rise;
         fall_pulse <= act & fall;
         toggle_pulse <= ev;
         toggle_cnt <= clr ? '0 : (ev && !(&toggle_cnt)) ? toggle_cnt + CNT_W'(1) : toggle_cnt;
         stuck_now <= nxt == STUCK;
         stuck_sticky <= nxt == STUCK ? 1'b1 : clr ? 1'b0 : stuck_sticky;
         stuck_level <= nxt == STUCK ? s : stuck_level;
      end
   assign state = st;
endmodule

// File: doc/toggle_watchdog.md
Name: toggle_watchdog

Overview:
Synthesizable RTL monitor that consumes a single-bit signal (`sig_in`) and proves it is toggling. It reports every rising, falling and either-direction edge as a one-cycle pulse and keeps a saturating toggle count. It flags a stuck condition when no edge occurs within a programmable cycle window. It is the hardware counterpart of the bench-level toggle assertion and sits downstream of any block whose output must toggle (strobes, heartbeats, divided clocks).

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchronizer; legal 0..3; 0 means `sig_in` is already in the `clk` domain.
- TIMEOUT_W, 16, width of `timeout_cycles` and of the internal idle counter.
- CNT_W, 16, width of `toggle_cnt`.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  monitor enable
- clr  in  1  synchronous clear of `toggle_cnt` and `stuck_sticky`
- sig_in  in  1  monitored signal
- timeout_cycles  in  TIMEOUT_W  edge-free window length; 0 disables stuck detection
- rise_pulse  out  1  one cycle high per 0->1 edge
- fall_pulse  out  1  one cycle high per 1->0 edge
- toggle_pulse  out  1  `rise_pulse | fall_pulse`
- toggle_cnt  out  CNT_W  saturating count of edges
- stuck_now  out  1  live stuck indication
- stuck_sticky  out  1  latched stuck indication, cleared only by `clr` or `rst`
- stuck_level  out  1  value of the synchronized signal when stuck was declared
- state  out  2  FSM state, for debug

Behaviour:
- Reset (async, rst=1):
  - All outputs 0; state = DISABLED.
  - Synchronizer flops, prev-sample register and idle counter are 0.
- Sampling:
  - `s` is `sig_in` after SYNC_STAGES flops.
  - `prev` is `s` registered.
  - An edge is `s != prev`, qualified only in MONITOR and STUCK.
- Latency:
  - Pulses, count and stuck flags are registered.
  - With SYNC_STAGES=0, an edge sampled at posedge k produces a pulse high from posedge k to posedge k+1.
  - Each synchronizer stage adds 1 cycle.
- FSM states: DISABLED=0, ARMING=1, MONITOR=2, STUCK=3.
  - DISABLED: pulses 0; idle counter 0; count and sticky hold. Goes to ARMING when en=1.
  - ARMING: exactly one cycle. Loads `prev`; no edge is reported, so a pre-existing level is never counted. Goes to MONITOR.
  - MONITOR:
    - On edge: idle counter returns to 0.
    - Otherwise idle counter increments, saturating.
    - When timeout_cycles != 0 and the idle count reaches timeout_cycles - 1 with no edge this cycle, go to STUCK. Result: STUCK is entered on exactly the timeout_cycles-th consecutive edge-free sample.
  - STUCK: stuck_now=1, stuck_sticky is set, stuck_level = `s`. On edge: pulse, count, clear idle counter, go to MONITOR (stuck_now drops the next cycle).
  - Any state with en=0: go to DISABLED next cycle.
- timeout_cycles:
  - Compared live; a mid-run change takes effect immediately.
  - If the idle count is already >= the new value (and the value is nonzero), go to STUCK next cycle.
- toggle_cnt:
  - +1 per qualified edge.
  - Saturates at 2^CNT_W - 1; no wrap.
- clr:
  - toggle_cnt becomes 0 and stuck_sticky becomes 0.
  - If an edge occurs in the same cycle, clr wins: count = 0, but the pulses still fire.
  - If a stuck detection occurs in the same cycle, the set wins: stuck_sticky = 1.
  - clr does not change the FSM state or stuck_now.
- rst asserted mid-operation: immediate return to reset values, regardless of clock.

Decomposition:
- Package `toggle_wd_pkg`:
  - `toggle_wd_state_e` enum (2 bits) with DISABLED/ARMING/MONITOR/STUCK.
  - Localparam `TW_SYNC_MAX = 3`.
- One sub-module: `sync_edge_det`.
  - Contains the SYNC_STAGES synchronizer and the `prev` register.
  - Outputs `s`, `rise`, `fall` (combinational).
- The FSM, idle counter, toggle counter and flags stay in `toggle_watchdog`.

Test Plan:
1. Reset, then en=1, SYNC_STAGES=0, timeout=8, sig_in toggled every 10 cycles -> rise/fall alternate 1-cycle pulses; stuck_now rises on the 8th edge-free sample after each edge and drops 1 cycle after the next edge; toggle_cnt=5 after 5 toggles.
2. sig_in held at 1 before en rises; en=1; no toggle -> no pulse during ARMING; STUCK after exactly 8 cycles in MONITOR; stuck_level=1, stuck_sticky=1; sticky stays 1 after a later toggle until clr.
3. CNT_W=4, 20 toggles -> toggle_cnt saturates at 15; clr pulsed together with a 21st edge -> toggle_cnt=0 and toggle_pulse=1 in that cycle.
4. timeout_cycles=0 with sig_in idle for 1000 cycles -> stuck_now stays 0; then write timeout=5 while the idle count is >5 -> stuck_now=1 the next cycle.
5. SYNC_STAGES=2, single toggle -> pulse appears 2 cycles later than with SYNC_STAGES=0.
6. rst asserted mid-STUCK, between clock edges -> all outputs 0 immediately, state=DISABLED; after release with en=1 -> ARMING then MONITOR, toggle_cnt=0.
